// File: rtl/display_arbiter.sv
// display_arbiter: time-shares the hex display between N requesters.
// Each grant lasts at least HOLD_CYCLES clocks; with nobody requesting,
// the background idle_value is shown instead.
// Build option DISPLAY_ARB_RR_EN: defined selects round-robin arbitration,
// undefined selects fixed priority (lowest index wins).
module display_arbiter #(
   parameter int N           = 3,
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 25_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] values,
   input  logic [WIDTH-1:0]   idle_value,
   output logic [N-1:0]       gnt,
   output logic [WIDTH-1:0]   value,
   output logic               held
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           r_state, w_stateNext;
   logic [N-1:0]     r_gnt, w_gntNext;
   logic [WIDTH-1:0] r_value, w_valueNext;
   logic [CW-1:0]    r_count, w_countNext;
   logic [IW-1:0]    r_owner, w_ownerNext;
   logic [IW-1:0]    w_winner;
   logic             w_anyReq;
   logic             w_load;
   logic [WIDTH-1:0] w_vals [N];

   assign w_anyReq = |req;

   // Split the packed value bus into one slice per requester
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_vals[i] = values[i*WIDTH +: WIDTH];
      end
   end

`ifdef DISPLAY_ARB_RR_EN
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;
   logic          w_found;

   // Round-robin search starting after the last owner, so the owner comes last
   always_comb begin
      w_winner = r_ptr;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = IW'((int'(r_ptr) + k) % N);
         if (!w_found && req[w_idx]) begin
            w_winner = w_idx;
            w_found  = 1'b1;
         end
      end
   end

   // Pointer remembers the most recent winner of any grant load
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= LAST;
      end else if (w_load) begin
         r_ptr <= w_winner;
      end
   end
`else
   // Fixed priority: the lowest requesting index wins
   always_comb begin
      w_winner = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[IW'(k)]) begin
            w_winner = IW'(k);
         end
      end
   end
`endif

   // Next-state logic: dwell countdown, expiry re-arbitration and value muxing
   always_comb begin
      w_stateNext = r_state;
      w_gntNext   = r_gnt;
      w_ownerNext = r_owner;
      w_countNext = r_count;
      w_valueNext = w_vals[r_owner];
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            w_gntNext   = '0;
            w_countNext = '0;
            w_valueNext = idle_value;
            if (w_anyReq) begin
               w_load = 1'b1;
            end
         end
         GRANT: begin
            if (r_count != '0) begin
               w_countNext = r_count - CW'(1);
            end else if (!w_anyReq) begin
               w_stateNext = IDLE;
               w_gntNext   = '0;
               w_valueNext = idle_value;
            end else if (w_winner != r_owner) begin
               w_load = 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_gntNext   = '0;
            w_valueNext = idle_value;
         end
      endcase
      if (w_load) begin
         w_stateNext = GRANT;
         w_gntNext   = {{(N-1){1'b0}}, 1'b1} << w_winner;
         w_ownerNext = w_winner;
         w_countNext = RELOAD;
         w_valueNext = w_vals[w_winner];
      end
   end

   // State, grant, value and dwell counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_value <= '0;
         r_count <= '0;
         r_owner <= '0;
      end else begin
         r_state <= w_stateNext;
         r_gnt   <= w_gntNext;
         r_value <= w_valueNext;
         r_count <= w_countNext;
         r_owner <= w_ownerNext;
      end
   end

   assign gnt   = r_gnt;
   assign value = r_value;
   assign held  = (r_state == GRANT) && (r_count != '0);

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: table-driven and hand-written sequences for display_arbiter
// with N=3, WIDTH=16, HOLD_CYCLES=4. Expected outputs go through a scoreboard queue.
module tb_display_arbiter;

   typedef struct packed {
      logic        r;
      logic [2:0]  rq;
      logic [15:0] v1;
      logic [2:0]  eg;
      logic [15:0] ev;
      logic        eh;
   } vec_t;

   typedef struct {
      logic [2:0]  g;
      logic [15:0] v;
      logic        h;
      string       nm;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [47:0] values;
   logic [15:0] idleValue;
   logic [2:0]  gnt;
   logic [15:0] value;
   logic        held;

   int   totalChecks = 0;
   int   badChecks   = 0;
   exp_t sbQueue[$];
   vec_t vecs[23];

   display_arbiter #(
      .N(3),
      .WIDTH(16),
      .HOLD_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .values(values),
      .idle_value(idleValue),
      .gnt(gnt),
      .value(value),
      .held(held)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge
   task automatic applyStimulus(input logic r, input logic [2:0] rq, input logic [15:0] v1,
                                input logic [2:0] eg, input logic [15:0] ev, input logic eh,
                                input string nm);
      exp_t e;
      @(negedge clk);
      rst       = r;
      req       = rq;
      values    = {16'hCAFE, v1, 16'hBEEF};
      idleValue = 16'h1234;
      e.g  = eg;
      e.v  = ev;
      e.h  = eh;
      e.nm = nm;
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Pop the oldest expectation and compare it with the outputs
   task automatic checkOutput();
      exp_t e;
      if (sbQueue.size() == 0) begin
         totalChecks++;
         badChecks++;
         $display("[TB] FAIL scoreboard: queue empty, got nothing want one entry");
      end else begin
         e = sbQueue.pop_front();
         totalChecks++;
         if (gnt !== e.g) begin
            badChecks++;
            $display("[TB] FAIL %s gnt: got=%b want=%b", e.nm, gnt, e.g);
         end
         totalChecks++;
         if (value !== e.v) begin
            badChecks++;
            $display("[TB] FAIL %s value: got=%h want=%h", e.nm, value, e.v);
         end
         totalChecks++;
         if (held !== e.h) begin
            badChecks++;
            $display("[TB] FAIL %s held: got=%b want=%b", e.nm, held, e.h);
         end
      end
   endtask

   task automatic runStep(input logic r, input logic [2:0] rq, input logic [15:0] v1,
                          input logic [2:0] eg, input logic [15:0] ev, input logic eh,
                          input string nm);
      applyStimulus(r, rq, v1, eg, ev, eh, nm);
      checkOutput();
   endtask

   // Main sequence: table vectors, build-specific contender check, reset and contention
   initial begin
      int          own;
      logic [2:0]  eg;
      logic [15:0] ev;
      logic        eh;

      rst       = 1'b1;
      req       = 3'b000;
      values    = {16'hCAFE, 16'h0001, 16'hBEEF};
      idleValue = 16'h1234;

      // reset, idle, minimum dwell, live tracking, lone owner
      vecs[0]  = '{1'b1, 3'b000, 16'h0001, 3'b000, 16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 3'b000, 16'h0001, 3'b000, 16'h0000, 1'b0};
      vecs[2]  = '{1'b0, 3'b000, 16'h0001, 3'b000, 16'h1234, 1'b0};
      vecs[3]  = '{1'b0, 3'b001, 16'h0001, 3'b001, 16'hBEEF, 1'b1};
      vecs[4]  = '{1'b0, 3'b000, 16'h0001, 3'b001, 16'hBEEF, 1'b1};
      vecs[5]  = '{1'b0, 3'b000, 16'h0001, 3'b001, 16'hBEEF, 1'b1};
      vecs[6]  = '{1'b0, 3'b000, 16'h0001, 3'b001, 16'hBEEF, 1'b0};
      vecs[7]  = '{1'b0, 3'b000, 16'h0001, 3'b000, 16'h1234, 1'b0};
      vecs[8]  = '{1'b0, 3'b010, 16'h0001, 3'b010, 16'h0001, 1'b1};
      vecs[9]  = '{1'b0, 3'b010, 16'h0002, 3'b010, 16'h0002, 1'b1};
      vecs[10] = '{1'b0, 3'b000, 16'h0002, 3'b010, 16'h0002, 1'b1};
      vecs[11] = '{1'b0, 3'b000, 16'h0002, 3'b010, 16'h0002, 1'b0};
      vecs[12] = '{1'b0, 3'b000, 16'h0002, 3'b000, 16'h1234, 1'b0};
      vecs[13] = '{1'b0, 3'b001, 16'h0002, 3'b001, 16'hBEEF, 1'b1};
      vecs[14] = '{1'b0, 3'b001, 16'h0002, 3'b001, 16'hBEEF, 1'b1};
      vecs[15] = '{1'b0, 3'b001, 16'h0002, 3'b001, 16'hBEEF, 1'b1};
      for (int i = 16; i < 23; i++) begin
         vecs[i] = '{1'b0, 3'b001, 16'h0002, 3'b001, 16'hBEEF, 1'b0};
      end

      for (int i = 0; i < 23; i++) begin
         runStep(vecs[i].r, vecs[i].rq, vecs[i].v1, vecs[i].eg, vecs[i].ev, vecs[i].eh,
                 $sformatf("vec%0d", i));
      end

`ifdef DISPLAY_ARB_RR_EN
      // Contender arrives with the counter at zero and takes over one edge later
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b1, "contend_take");
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b1, "contend_hold1");
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b1, "contend_hold2");
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b0, "contend_last");
      runStep(1'b0, 3'b011, 16'h0002, 3'b001, 16'hBEEF, 1'b1, "contend_rotate");
`else
      // Lower-index owner keeps the grant; a higher-index owner yields at expiry
      runStep(1'b0, 3'b011, 16'h0002, 3'b001, 16'hBEEF, 1'b0, "prio_keep");
      runStep(1'b0, 3'b010, 16'h0002, 3'b010, 16'h0002, 1'b1, "prio_handoff");
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b1, "prio_hold1");
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b1, "prio_hold2");
      runStep(1'b0, 3'b011, 16'h0002, 3'b010, 16'h0002, 1'b0, "prio_last");
      runStep(1'b0, 3'b011, 16'h0002, 3'b001, 16'hBEEF, 1'b1, "prio_yield");
`endif

      // Reset in the middle of a grant, then arbitrate from the reset pointer
      runStep(1'b1, 3'b000, 16'h0002, 3'b000, 16'h0000, 1'b0, "rst_a");
      runStep(1'b0, 3'b100, 16'h0002, 3'b100, 16'hCAFE, 1'b1, "own2_load");
      runStep(1'b0, 3'b100, 16'h0002, 3'b100, 16'hCAFE, 1'b1, "own2_hold");
      runStep(1'b1, 3'b100, 16'h0002, 3'b000, 16'h0000, 1'b0, "rst_mid");
      runStep(1'b0, 3'b110, 16'h0002, 3'b010, 16'h0002, 1'b1, "after_rst");
      runStep(1'b1, 3'b000, 16'h0002, 3'b000, 16'h0000, 1'b0, "rst_b");

      // Continuous contention with every requester active
      for (int c = 0; c < 17; c++) begin
`ifdef DISPLAY_ARB_RR_EN
         own = (c / 4) % 3;
         eh  = ((c % 4) != 3);
`else
         own = 0;
         eh  = (c < 3);
`endif
         eg = 3'b001 << own;
         ev = (own == 0) ? 16'hBEEF : (own == 1) ? 16'h0002 : 16'hCAFE;
         runStep(1'b0, 3'b111, 16'h0002, eg, ev, eh, $sformatf("contention%0d", c));
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
